// File: rtl/motor_pkg.sv
// motor_pkg: shared types and helpers for the multi-channel H-bridge controller.
//   state_e  - per-channel sequencing state (RUN, RAMP_DN, DEAD)
//   pwm_max  - last PWM counter value for a given duty width (2^w - 2)
package motor_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      RAMP_DN = 2'd1,
      DEAD    = 2'd2
   } state_e;

   // Counter wraps here so a duty of 2^w-1 holds the output constantly high.
   function automatic int unsigned pwm_max(input int unsigned dw);
      return (32'd1 << dw) - 32'd2;
   endfunction

endpackage

// File: rtl/motor_channel.sv
// motor_channel: one H-bridge channel. Slew-limits the applied duty, sequences
// direction reversal through ramp-down and a dead interval, and registers the
// PWM enable together with the IN1/IN2 direction pins.
// Build option: MOTOR_BRAKE_EN drives IN1=IN2=1 (brake) during the dead
// interval; without it both pins are 0 (coast).
//   clk, rst     - clock, synchronous active-low reset
//   en           - global enable; 0 clears applied duty and gates PWM
//   pe           - period-end strobe from the shared PWM counter
//   cnt          - shared PWM counter
//   dir, duty    - requested direction and duty
//   pwm_out      - registered PWM enable
//   in1, in2     - registered direction pins
//   busy         - registered, high while ramping down or dead
module motor_channel
   import motor_pkg::*;
#(
   parameter int unsigned DUTY_W       = 8,
   parameter int unsigned RAMP_STEP    = 16,
   parameter int unsigned DEAD_PERIODS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              pe,
   input  logic [DUTY_W-1:0] cnt,
   input  logic              dir,
   input  logic [DUTY_W-1:0] duty,
   output logic              pwm_out,
   output logic              in1,
   output logic              in2,
   output logic              busy
);

   localparam int unsigned DC_W = $clog2(DEAD_PERIODS + 1);

`ifdef MOTOR_BRAKE_EN
   localparam logic DEAD_LVL = 1'b1;
`else
   localparam logic DEAD_LVL = 1'b0;
`endif

   state_e            state;
   logic [DUTY_W-1:0] ad;
   logic              adir;
   logic [DC_W-1:0]   dead_cnt;

   logic [DUTY_W-1:0] up_diff, dn_diff;
   logic [DUTY_W-1:0] up_step, dn_step, rd_step;

   // Slew-limited step sizes toward the request and toward zero.
   always_comb begin
      up_diff = duty - ad;
      dn_diff = ad - duty;
      up_step = '0;
      dn_step = '0;
      if (duty > ad)
         up_step = (32'(up_diff) > RAMP_STEP) ? DUTY_W'(RAMP_STEP) : up_diff;
      if (ad > duty)
         dn_step = (32'(dn_diff) > RAMP_STEP) ? DUTY_W'(RAMP_STEP) : dn_diff;
      rd_step = (32'(ad) > RAMP_STEP) ? DUTY_W'(RAMP_STEP) : ad;
   end

   // Sequencer and output registers; applied values only move on period end.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= RUN;
         ad       <= '0;
         adir     <= 1'b0;
         dead_cnt <= '0;
         pwm_out  <= 1'b0;
         in1      <= 1'b1;
         in2      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         pwm_out <= en && (cnt < ad);
         busy    <= (state != RUN);
         if (state == DEAD) begin
            in1 <= DEAD_LVL;
            in2 <= DEAD_LVL;
         end else begin
            in1 <= ~adir;
            in2 <= adir;
         end

         if (!en) begin
            // Sequencing frozen; a pending reversal resumes from ad = 0.
            ad <= '0;
         end else if (pe) begin
            unique case (state)
               RUN: begin
                  if (dir != adir) begin
                     if (ad == '0) begin
                        state    <= DEAD;
                        dead_cnt <= DC_W'(DEAD_PERIODS);
                     end else begin
                        state <= RAMP_DN;
                     end
                  end else begin
                     ad <= ad + up_step - dn_step;
                  end
               end
               RAMP_DN: begin
                  if (dir == adir) begin
                     state <= RUN;
                  end else begin
                     ad <= ad - rd_step;
                     if (ad == rd_step) begin
                        state    <= DEAD;
                        dead_cnt <= DC_W'(DEAD_PERIODS);
                     end
                  end
               end
               DEAD: begin
                  dead_cnt <= dead_cnt - DC_W'(1);
                  if (dead_cnt == DC_W'(1)) begin
                     state <= RUN;
                     adir  <= dir;
                  end
               end
               default: state <= RUN;
            endcase
         end
      end
   end

endmodule

// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: multi-channel H-bridge controller for L298-class drivers.
// Shared prescaler and PWM counter feed CHANNELS motor_channel instances.
// Build option: MOTOR_BRAKE_EN selects brake (IN1=IN2=1) instead of coast
// (IN1=IN2=0) during the reversal dead interval.
//   clk, rst    - 50 MHz clock, synchronous active-low reset
//   en          - global enable
//   dir         - requested direction per channel (0 fwd, 1 rev)
//   duty_cycle  - requested duty, channel k at [k*DUTY_W +: DUTY_W]
//   pwm_out     - per-channel PWM to ENx
//   in1, in2    - per-channel direction pins
//   busy        - per-channel, high during ramp-down or dead interval
//   led         - registered low byte of channel 0 duty request
module motor_drive_ctrl
   import motor_pkg::*;
#(
   parameter int unsigned CHANNELS     = 2,
   parameter int unsigned DUTY_W       = 8,
   parameter int unsigned PRESC        = 1960,
   parameter int unsigned RAMP_STEP    = 16,
   parameter int unsigned DEAD_PERIODS = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [CHANNELS-1:0]        dir,
   input  logic [CHANNELS*DUTY_W-1:0] duty_cycle,
   output logic [CHANNELS-1:0]        pwm_out,
   output logic [CHANNELS-1:0]        in1,
   output logic [CHANNELS-1:0]        in2,
   output logic [CHANNELS-1:0]        busy,
   output logic [7:0]                 led
);

   localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [DUTY_W-1:0] CNT_MAX = DUTY_W'(pwm_max(DUTY_W));

   logic [PW-1:0]     pcnt;
   logic [DUTY_W-1:0] cnt;
   logic              tick_c;
   logic              pe_c;

   assign tick_c = (pcnt == PW'(PRESC - 1));
   assign pe_c   = tick_c && (cnt == CNT_MAX);

   // Shared prescaler, PWM counter and LED register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pcnt <= '0;
         cnt  <= '0;
         led  <= '0;
      end else begin
         pcnt <= tick_c ? '0 : pcnt + PW'(1);
         if (tick_c)
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + DUTY_W'(1);
         led <= 8'(duty_cycle[DUTY_W-1:0]);
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      motor_channel #(
         .DUTY_W       (DUTY_W),
         .RAMP_STEP    (RAMP_STEP),
         .DEAD_PERIODS (DEAD_PERIODS)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .pe      (pe_c),
         .cnt     (cnt),
         .dir     (dir[k]),
         .duty    (duty_cycle[k*DUTY_W +: DUTY_W]),
         .pwm_out (pwm_out[k]),
         .in1     (in1[k]),
         .in2     (in2[k]),
         .busy    (busy[k])
      );
   end

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// tb_motor_drive_ctrl: checks motor_drive_ctrl period by period against a
// behavioural model of applied duty, reversal sequencing and pin levels.
// Honours MOTOR_BRAKE_EN for the expected dead-interval pin levels.
module tb_motor_drive_ctrl;

   localparam int CH    = 2;
   localparam int DW    = 8;
   localparam int STEP  = 16;
   localparam int DEADP = 2;
   localparam int PER   = 255;

`ifdef MOTOR_BRAKE_EN
   localparam logic BRK = 1'b1;
`else
   localparam logic BRK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [CH-1:0]    dir;
   logic [CH*DW-1:0] duty_cycle;
   logic [CH-1:0]    pwm_out, in1, in2, busy;
   logic [7:0]       led;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: applied duty, applied direction, reversal ramp pending, dead periods left.
   int   m_ad   [CH];
   logic m_adir [CH];
   bit   m_rev  [CH];
   int   m_dead [CH];

   always #5 clk = ~clk;

   motor_drive_ctrl #(
      .CHANNELS     (CH),
      .DUTY_W       (DW),
      .PRESC        (1),
      .RAMP_STEP    (STEP),
      .DEAD_PERIODS (DEADP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .dir        (dir),
      .duty_cycle (duty_cycle),
      .pwm_out    (pwm_out),
      .in1        (in1),
      .in2        (in2),
      .busy       (busy),
      .led        (led)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < CH; k++) begin
         m_ad[k]   = 0;
         m_adir[k] = 1'b0;
         m_rev[k]  = 1'b0;
         m_dead[k] = 0;
      end
   endtask

   // One period-end decision for channel k.
   task automatic model_step(input int k, input logic d, input int du, input logic e);
      int diff;
      if (!e) begin
         m_ad[k] = 0;
      end else if (m_dead[k] > 0) begin
         m_dead[k]--;
         if (m_dead[k] == 0) m_adir[k] = d;
      end else if (m_rev[k]) begin
         if (d == m_adir[k]) begin
            m_rev[k] = 1'b0;
         end else begin
            m_ad[k] -= (m_ad[k] < STEP) ? m_ad[k] : STEP;
            if (m_ad[k] == 0) begin
               m_rev[k]  = 1'b0;
               m_dead[k] = DEADP;
            end
         end
      end else if (d != m_adir[k]) begin
         if (m_ad[k] == 0) m_dead[k] = DEADP;
         else              m_rev[k]  = 1'b1;
      end else begin
         diff = du - m_ad[k];
         if (diff > STEP)  diff = STEP;
         if (diff < -STEP) diff = -STEP;
         m_ad[k] += diff;
      end
   endtask

   // Apply a request for one full PWM period and check every clock of it.
   task automatic run_period(input logic [CH-1:0] d, input int du0, input int du1, input logic e);
      int            exp_hi [CH];
      int            hi     [CH];
      int            bad    [CH];
      logic [CH-1:0] e_in1, e_in2, e_busy;
      int            du [CH];
      du[0] = du0;
      du[1] = du1;
      dir        = d;
      duty_cycle = {DW'(du1), DW'(du0)};
      en         = e;
      for (int k = 0; k < CH; k++) begin
         exp_hi[k] = e ? m_ad[k] : 0;
         hi[k]     = 0;
         bad[k]    = 0;
         e_in1[k]  = (m_dead[k] > 0) ? BRK : ~m_adir[k];
         e_in2[k]  = (m_dead[k] > 0) ? BRK : m_adir[k];
         e_busy[k] = m_rev[k] || (m_dead[k] > 0);
      end
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         for (int k = 0; k < CH; k++) begin
            if (pwm_out[k]) hi[k]++;
            if (pwm_out[k] !== (i < exp_hi[k])) bad[k]++;
         end
         if (i == 0 || i == PER - 1) begin
            check("in1", 32'(in1), 32'(e_in1));
            check("in2", 32'(in2), 32'(e_in2));
            check("busy", 32'(busy), 32'(e_busy));
         end
      end
      for (int k = 0; k < CH; k++) begin
         check($sformatf("pwm_high_ch%0d", k), 32'(hi[k]), 32'(exp_hi[k]));
         check($sformatf("pwm_shape_ch%0d", k), 32'(bad[k]), 32'd0);
      end
      check("led", 32'(led), 32'(du0 & 255));
      for (int k = 0; k < CH; k++) model_step(k, d[k], du[k], e);
   endtask

   // Hold reset three clocks, checking reset values after each.
   task automatic do_reset(input string tag);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check({tag, "_pwm"}, 32'(pwm_out), 32'd0);
         check({tag, "_in1"}, 32'(in1), 32'd3);
         check({tag, "_in2"}, 32'(in2), 32'd0);
         check({tag, "_busy"}, 32'(busy), 32'd0);
         check({tag, "_led"}, 32'(led), 32'd0);
      end
      model_reset();
      rst = 1'b1;
   endtask

   initial begin
      logic [CH-1:0] rd;
      rst        = 1'b0;
      en         = 1'b0;
      dir        = '0;
      duty_cycle = '0;
      model_reset();
      do_reset("reset");

      // Ramp-up to 128; channel 1 reverses from standstill straight into dead.
      repeat (10) run_period(2'b10, 128, 100, 1'b1);
      // Extremes: full scale, then back to zero.
      repeat (18) run_period(2'b10, 255, 100, 1'b1);
      repeat (18) run_period(2'b10, 0, 100, 1'b1);
      // Reversal from 64.
      repeat (6)  run_period(2'b10, 64, 100, 1'b1);
      repeat (10) run_period(2'b11, 64, 100, 1'b1);
      // Abort a reversal during ramp-down.
      repeat (2)  run_period(2'b10, 64, 100, 1'b1);
      repeat (8)  run_period(2'b11, 64, 100, 1'b1);
      // Enable drop at duty 200.
      repeat (16) run_period(2'b11, 200, 100, 1'b1);
      run_period(2'b11, 200, 100, 1'b0);
      repeat (5)  run_period(2'b11, 200, 100, 1'b1);
      // Reverse channel 0 into dead, then reset part-way through it.
      for (int g = 0; g < 20 && m_dead[0] == 0; g++) run_period(2'b10, 32, 100, 1'b1);
      repeat (100) @(negedge clk);
      do_reset("mid_reset");

      // Randomized requests.
      rd = '0;
      for (int p = 0; p < 40; p++) begin
         for (int k = 0; k < CH; k++)
            if ($urandom_range(0, 5) == 0) rd[k] = ~rd[k];
         run_period(rd, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    ($urandom_range(0, 9) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/motor_drive_ctrl.md
# motor_drive_ctrl

Multi-channel H-bridge motor controller for L298-class drivers. Each channel takes a requested duty and direction from switches or upstream logic and produces a glitch-free PWM enable plus IN1/IN2 direction pins. Each channel slew-limits duty changes. Direction reversal always goes through ramp-down, then a dead/brake interval, then ramp-up, so the bridge is never reversed under load. The block sits between the board I/O (switches/LEDs) and the driver pins, and replaces the single-channel fixed-direction top level.

## Interface
- CHANNELS, 2, number of independent motor channels
- DUTY_W, 8, duty width; PWM counter runs 0..2^DUTY_W-2 (period = 2^DUTY_W-1 ticks)
- PRESC, 1960, clocks per PWM tick (50 MHz / (1960·255) ≈ 100 Hz); must be ≥1
- RAMP_STEP, 16, max change of applied duty per PWM period; must be ≥1
- DEAD_PERIODS, 2, PWM periods spent in the dead interval on reversal; must be ≥1

- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-low reset
- en  in  1  global enable; 0 forces all PWM low
- dir  in  CHANNELS  requested direction per channel (0 = forward, 1 = reverse)
- duty_cycle  in  CHANNELS·DUTY_W  requested duty per channel; channel k at bits [k·DUTY_W +: DUTY_W]
- pwm_out  out  CHANNELS  PWM to ENx
- in1  out  CHANNELS  direction pin 1
- in2  out  CHANNELS  direction pin 2
- busy  out  CHANNELS  1 while a channel is in RAMP_DN or DEAD
- led  out  8  duty_cycle[7:0] of channel 0 (registered)

## Operation
- Shared prescaler and PWM counter `cnt`. A tick occurs every PRESC clocks. On each tick, cnt increments and wraps from 2^DUTY_W-2 to 0. `pe` (period end) = tick with cnt at max.
- Per channel: applied duty `ad`, applied direction `adir`, state ∈ {RUN, RAMP_DN, DEAD}, dead counter.
- pwm_out = registered (cnt < ad) & en. ad = 2^DUTY_W-1 gives constant high; ad = 0 gives constant low.
- All ad/adir/state updates happen only on pe, so no PWM period is ever truncated.
- RUN, dir == adir: ad moves toward duty_cycle by min(RAMP_STEP, |diff|). Saturating, no wrap.
- RUN, dir ≠ adir: if ad ≠ 0, go to RAMP_DN. If ad == 0, go to DEAD and load the counter with DEAD_PERIODS.
- RAMP_DN: ad decreases by min(RAMP_STEP, ad). When ad reaches 0, go to DEAD (same pe) and load the counter.
- RAMP_DN, dir returns to adir before ad reaches 0: go back to RUN and ramp toward duty_cycle. No reversal occurs.
- DEAD: pwm_out 0. in1/in2 driven per the brake/coast rule in Configuration. Counter decrements each pe. On the pe where the counter reaches 0, adir ← dir (sampled then), state ← RUN, ad stays 0.
- In RUN and RAMP_DN: in1 = ~adir, in2 = adir.
- en = 0: ad cleared to 0 immediately, pwm_out 0, dead counter and state held. A pending reversal proceeds through DEAD once ad = 0.

## Timing
- Reset values: pwm_out 0, in1 all 1, in2 all 0, busy 0, led 0, ad 0, adir 0, state RUN, cnt 0, prescaler 0.
- Duty request to first changed PWM edge: at most one PWM period plus 1 clock.
- Full-scale ramp: ceil(target/RAMP_STEP) periods.
- Reversal from duty D: ceil(D/RAMP_STEP) + DEAD_PERIODS periods, then ramp-up.
- in1/in2 and pwm_out are registered together; in1/in2 change only while pwm_out is 0.
- rst low mid-operation: all state returns to reset values on the next clock, regardless of phase.

## Configuration
- MOTOR_BRAKE_EN defined: during DEAD, in1 = in2 = 1 (dynamic brake).
- MOTOR_BRAKE_EN undefined: during DEAD, in1 = in2 = 0 (coast).
- All other behaviour is identical in both builds.

## Structure
- Package `motor_pkg`: state enum (RUN, RAMP_DN, DEAD) and the helper constant PWM_MAX = 2^DUTY_W-2.
- Top `motor_drive_ctrl` holds the shared prescaler/counter and the led register. It generates CHANNELS instances of sub-module `motor_channel` (state machine, ramp, dead counter, output registers).

## Test plan
Setup for all tests: DUTY_W=8, PRESC=1, RAMP_STEP=16, DEAD_PERIODS=2.
- Reset: hold rst=0 for 3 clocks -> pwm_out=0, in1=all 1, in2=0, busy=0, led=0.
- Ramp-up: dir=0, duty=128 -> ad steps 16, 32, …, 128 over 8 periods. Steady state: pwm high 128 of 255 clocks per period.
- Extremes: duty=255 -> pwm constantly high once ramped. Then duty=0 -> ramps down, then constantly low. Edges only at period boundaries.
- Reversal at duty=64: set dir=1 -> busy=1 and 4 ramp-down periods, then 2 DEAD periods with in1=in2=1 (MOTOR_BRAKE_EN) or 0 (undefined). Then in1=0, in2=1, ramp back to 64, busy=0.
- Abort: during RAMP_DN set dir back to 0 -> no DEAD, in1/in2 unchanged, ramp back up.
- Mid-operation: rst=0 during DEAD -> reset values next clock. Separately, en=0 at duty=200 -> pwm 0 the next clock, ramp restarts from 0 on en=1.
